// File: rtl/sd_cmd_resp_serializer_pkg.sv
// Shared definitions for the SD CMD-line response serializer and its CRC7 engine.
package sd_cmd_resp_serializer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int unsigned CRC7_W    = 7;
    localparam logic [6:0]  CRC7_POLY = 7'h09;   // x^7 + x^3 + 1

    localparam int unsigned SHORT_LEN = 48;
    localparam int unsigned LONG_LEN  = 136;
    localparam int unsigned FRAME_W   = LONG_LEN;
    localparam int unsigned BIT_CNT_W = 8;

    // Payload bits sent ahead of the CRC field in each frame type
    localparam int unsigned SHORT_DATA_BITS = 40;
    localparam int unsigned LONG_DATA_BITS  = 128;
    // Long frames exclude their first byte from the CRC
    localparam int unsigned LONG_CRC_FIRST  = 8;

    // Short-frame field positions inside the 128-bit payload
    localparam int unsigned SHORT_DATA_MSB = 127;
    localparam int unsigned SHORT_DATA_LSB = 88;
    localparam int unsigned SHORT_CRC_MSB  = 87;
    localparam int unsigned SHORT_CRC_LSB  = 81;

    // One serial CRC7 step, initial value 0, MSB-first message
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
        logic fb;
        fb = bit_in ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/sd_crc7_serial.sv
// Bit-serial CRC7 engine; clear has priority over enable.
module sd_crc7_serial
    import sd_cmd_resp_serializer_pkg::*;
(
    input  logic              clk,
    input  logic              clear,
    input  logic              enable,
    input  logic              bit_in,
    output logic [CRC7_W-1:0] crc
);

    logic [CRC7_W-1:0] crc_q, crc_d;

    // Next CRC value: clear, advance by one message bit, or hold
    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = '0;
        end else if (enable) begin
            crc_d = crc7_step(crc_q, bit_in);
        end
    end

    // CRC register
    always_ff @(posedge clk) begin
        crc_q <= crc_d;
    end

    assign crc = crc_q;

endmodule

// File: rtl/sd_cmd_resp_serializer.sv
// Serializes one SD command-line response (48-bit or 136-bit) with optional CRC7.
module sd_cmd_resp_serializer
    import sd_cmd_resp_serializer_pkg::*;
#(
    parameter int unsigned NCR_W  = 4,
    parameter int unsigned CRC_EN = 1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic             long_resp,
    input  logic [127:0]     payload,
    input  logic [NCR_W-1:0] ncr,
    input  logic             abort,
    output logic             cmd_out,
    output logic             busy,
    output logic             done
);

    state_e                 state_q, state_d;
    logic [FRAME_W-1:0]     shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [NCR_W-1:0]       dly_q, dly_d;
    logic                   long_q, long_d;

    logic                   crc_clr;
    logic                   crc_en;
    logic [CRC7_W-1:0]      crc;
    logic [CRC7_W-1:0]      short_field;

    logic [BIT_CNT_W-1:0]   data_len;
    logic [BIT_CNT_W-1:0]   crc_end;
    logic [BIT_CNT_W-1:0]   cov_first;
    logic [BIT_CNT_W-1:0]   last_idx;
    logic                   in_cov;
    logic                   in_crc;
    logic                   crc_bit;
    logic                   frame_bit;

    // The shift register already holds the verbatim field; with CRC enabled it holds zeros there
    assign short_field = (CRC_EN != 0) ? '0 : payload[SHORT_CRC_MSB:SHORT_CRC_LSB];

    // Frame geometry for the latched frame type and the bit currently on the line
    always_comb begin
        data_len  = long_q ? BIT_CNT_W'(LONG_DATA_BITS) : BIT_CNT_W'(SHORT_DATA_BITS);
        cov_first = long_q ? BIT_CNT_W'(LONG_CRC_FIRST) : '0;
        last_idx  = long_q ? BIT_CNT_W'(LONG_LEN - 1)   : BIT_CNT_W'(SHORT_LEN - 1);
        crc_end   = data_len + BIT_CNT_W'(CRC7_W);
        in_cov    = (state_q == ST_SHIFT) && (bit_cnt_q >= cov_first) && (bit_cnt_q < data_len);
        in_crc    = (bit_cnt_q >= data_len) && (bit_cnt_q < crc_end);
        // Both data lengths are multiples of 8, so the low counter bits index the CRC field
        crc_bit   = crc[3'd6 - bit_cnt_q[2:0]];
        frame_bit = ((CRC_EN != 0) && in_crc) ? crc_bit : shift_q[FRAME_W-1];
    end

    // Next-state and datapath updates for IDLE/WAIT/SHIFT/DONE
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        dly_d     = dly_q;
        long_d    = long_q;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_WAIT;
                    bit_cnt_d = '0;
                    dly_d     = ncr;
                    long_d    = long_resp;
                    crc_clr   = 1'b1;
                    if (long_resp) begin
                        shift_d = {payload, {CRC7_W{1'b0}}, 1'b1};
                    end else begin
                        shift_d = {payload[SHORT_DATA_MSB:SHORT_DATA_LSB], short_field, 1'b1,
                                   {(FRAME_W - SHORT_LEN){1'b0}}};
                    end
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_DONE;
                end else if (dly_q == '0) begin
                    state_d = ST_SHIFT;
                end else begin
                    dly_d = dly_q - 1'b1;
                end
            end
            ST_SHIFT: begin
                crc_en = in_cov;
                if (abort) begin
                    state_d = ST_DONE;
                end else begin
                    shift_d   = {shift_q[FRAME_W-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == last_idx) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, shift register and counters with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            dly_q     <= '0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            dly_q     <= dly_d;
            long_q    <= long_d;
        end
    end

    sd_crc7_serial u_crc7 (
        .clk    (CLK),
        .clear  (crc_clr | ~RESET),
        .enable (crc_en),
        .bit_in (shift_q[FRAME_W-1]),
        .crc    (crc)
    );

    // Abort masks the line combinationally in the same cycle it is raised
    assign cmd_out = ((state_q == ST_SHIFT) && !abort) ? frame_bit : 1'b1;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_sd_cmd_resp_serializer.sv
// Self-checking bench: directed and random responses against a frame-level reference model.
module tb_sd_cmd_resp_serializer;

    localparam int NW = 4;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          start;
    logic          long_resp;
    logic [127:0]  payload;
    logic [NW-1:0] ncr;
    logic          abort;
    logic          cmd_a, busy_a, done_a;   // CRC_EN = 1
    logic          cmd_b, busy_b, done_b;   // CRC_EN = 0

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    sd_cmd_resp_serializer #(.NCR_W(NW), .CRC_EN(1)) u_dut_crc (
        .CLK(CLK), .RESET(RESET), .start(start), .long_resp(long_resp),
        .payload(payload), .ncr(ncr), .abort(abort),
        .cmd_out(cmd_a), .busy(busy_a), .done(done_a)
    );

    sd_cmd_resp_serializer #(.NCR_W(NW), .CRC_EN(0)) u_dut_raw (
        .CLK(CLK), .RESET(RESET), .start(start), .long_resp(long_resp),
        .payload(payload), .ncr(ncr), .abort(abort),
        .cmd_out(cmd_b), .busy(busy_b), .done(done_b)
    );

    // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1 (long division)
    function automatic logic [6:0] ref_crc7(input logic [127:0] msg, input int n);
        logic [7:0] rem;
        rem = '0;
        for (int i = n - 1; i >= -7; i--) begin
            rem = {rem[6:0], (i >= 0) ? msg[i] : 1'b0};
            if (rem[7]) rem = rem ^ 8'h89;
        end
        return rem[6:0];
    endfunction

    // Expected frame, right-aligned, first transmitted bit most significant
    function automatic logic [135:0] ref_frame(input logic lng, input logic [127:0] pl, input bit crc_en);
        logic [6:0] fld;
        if (!lng) begin
            fld = crc_en ? ref_crc7({88'b0, pl[127:88]}, 40) : pl[87:81];
            return {88'b0, pl[127:88], fld, 1'b1};
        end
        fld = crc_en ? ref_crc7({8'b0, pl[119:0]}, 120) : 7'h00;
        return {pl, fld, 1'b1};
    endfunction

    function automatic logic [127:0] rand_pl();
        logic [127:0] p;
        p = {$urandom, $urandom, $urandom, $urandom};
        p[127] = 1'b0;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Cycles from the accept edge until the start bit is on the line (bounded)
    task automatic wait_start(output int cyc);
        cyc = 0;
        while (cmd_a === 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    task automatic capture(input int nbits, input int pulse_at,
                           output logic [135:0] g_crc, output logic [135:0] g_raw);
        g_crc = '0;
        g_raw = '0;
        for (int i = 0; i < nbits; i++) begin
            g_crc = {g_crc[134:0], cmd_a};
            g_raw = {g_raw[134:0], cmd_b};
            if (pulse_at >= 0) begin
                start   = (i == pulse_at);
                payload = rand_pl();
            end
            tick();
        end
        start = (pulse_at >= 0) ? 1'b0 : start;
    endtask

    // One complete response starting from IDLE, with latency, content and done checks
    task automatic frame(input logic lng, input logic [127:0] pl, input int n,
                         input int pulse_at, output logic [135:0] g_crc);
        logic [135:0] g_raw;
        int cyc;
        long_resp = lng;
        payload   = pl;
        ncr       = NW'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        abort     = 1'b0;
        payload   = rand_pl();
        long_resp = ~lng;
        ncr       = NW'($urandom_range(0, 15));
        chk("busy_after_accept", 136'(busy_a), 136'(1));
        wait_start(cyc);
        chk("start_latency", 136'(cyc), 136'(n + 1));
        capture(lng ? 136 : 48, pulse_at, g_crc, g_raw);
        chk("frame_crc", g_crc, ref_frame(lng, pl, 1'b1));
        chk("frame_raw", g_raw, ref_frame(lng, pl, 1'b0));
        chk("done_pulse", 136'({done_a, done_b}), 136'(2'b11));
        chk("done_cmd_high", 136'({cmd_a, cmd_b}), 136'(2'b11));
        chk("done_busy", 136'(busy_a), 136'(1));
        tick();
        chk("idle_after_done", 136'({busy_a, done_a, cmd_a}), 136'(3'b001));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [127:0] p, p2;
        logic [135:0] g1, g0;
        int cyc, gap;

        RESET = 1'b0; start = 1'b0; abort = 1'b0;
        long_resp = 1'b0; payload = '0; ncr = '0;
        repeat (3) tick();
        chk("reset_outputs", 136'({cmd_a, busy_a, done_a, cmd_b, busy_b, done_b}), 136'(6'b100100));

        // Known R1 response, accepted on the first edge with reset released
        RESET = 1'b1;
        p = rand_pl(); p[127:88] = 40'h11_0000_0900;
        frame(1'b0, p, 2, -1, g1);
        chk("r1_cmd17_bits", g1, 136'h11_0000_0900_67);

        p = rand_pl(); p[127:88] = 40'h40_0000_0000;
        frame(1'b0, p, 0, -1, g1);
        chk("cmd0_bits", g1, 136'h40_0000_0000_95);

        p = {8'h3F, 120'b0};
        frame(1'b1, p, 1, -1, g1);
        chk("long_zero_crc", g1, {8'h3F, 120'b0, 8'h01});

        // Abort during bit 20 of a short frame
        p = rand_pl(); p[107] = 1'b0;
        long_resp = 1'b0; payload = p; ncr = NW'(1); start = 1'b1;
        tick();
        start = 1'b0;
        wait_start(cyc);
        capture(20, -1, g1, g0);
        chk("abort_prefix", g1, ref_frame(1'b0, p, 1'b1) >> 28);
        abort = 1'b1;
        #1;
        chk("abort_mask", 136'({cmd_a, cmd_b}), 136'(2'b11));
        tick();
        abort = 1'b0;
        chk("abort_done", 136'({done_a, busy_a, cmd_a}), 136'(3'b111));
        tick();
        chk("abort_idle", 136'({done_a, busy_a}), 136'(2'b00));
        frame(1'b0, rand_pl(), 2, -1, g1);

        // Abort in IDLE does nothing; abort together with start lets start win
        abort = 1'b1;
        tick();
        tick();
        chk("abort_in_idle", 136'({busy_a, done_a, cmd_a}), 136'(3'b001));
        frame(1'b1, rand_pl(), 0, -1, g1);

        // Start pulse in the middle of a frame is neither taken nor queued
        frame(1'b0, rand_pl(), 1, 10, g1);
        tick();
        chk("no_queued_frame", 136'({busy_a, cmd_a}), 136'(2'b01));

        // start held high: back-to-back frames
        p = rand_pl(); p2 = rand_pl();
        long_resp = 1'b0; payload = p; ncr = NW'(3); start = 1'b1;
        tick();
        payload = p2;
        wait_start(cyc);
        chk("b2b_latency", 136'(cyc), 136'(4));
        capture(48, -1, g1, g0);
        chk("b2b_frame1", g1, ref_frame(1'b0, p, 1'b1));
        chk("b2b_done1", 136'(done_a), 136'(1));
        gap = 0;
        while (cmd_a === 1'b1 && gap < 40) begin
            gap++;
            tick();
        end
        // DONE cycle + IDLE cycle + (ncr+1) delay cycles
        chk("b2b_gap", 136'(gap), 136'(6));
        start = 1'b0;
        payload = rand_pl();
        capture(48, -1, g1, g0);
        chk("b2b_frame2", g1, ref_frame(1'b0, p2, 1'b1));
        chk("b2b_frame2_raw", g0, ref_frame(1'b0, p2, 1'b0));
        chk("b2b_done2", 136'(done_a), 136'(1));
        tick();
        chk("b2b_idle", 136'({busy_a, cmd_a}), 136'(2'b01));

        // Reset in the middle of a long frame
        long_resp = 1'b1; payload = rand_pl(); ncr = '0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_start(cyc);
        capture(30, -1, g1, g0);
        RESET = 1'b0;
        tick();
        chk("reset_mid_frame", 136'({cmd_a, busy_a, done_a, cmd_b, busy_b, done_b}), 136'(6'b100100));
        RESET = 1'b1;
        tick();
        chk("reset_no_done", 136'({done_a, busy_a, cmd_a}), 136'(3'b001));

        // Random responses
        for (int k = 0; k < 8; k++) begin
            frame(1'($urandom_range(0, 1)), rand_pl(), int'($urandom_range(0, 4)), -1, g1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
